// File: rtl/hazard_noc_ctrl.sv
// hazard_noc_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Generates EX-stage forwarding selects, load-use bubbles and branch/jump
// flushes, and sequences the NoC send handshake for an instruction in EX,
// holding the pipeline until the router accepts it or a timeout fires.
// Optional feature macro: HAZARD_PERF_EN (adds saturating stall/flush counters).
module hazard_noc_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] Radd_E,
    input  logic       Mem_Read_E,
    input  logic       RegW_enable_E,
    input  logic [4:0] Radd_M,
    input  logic       RegW_enable_M,
    input  logic [4:0] Radd_W,
    input  logic       RegW_enable_W,
    input  logic       branch_taken_E,
    input  logic       Jump_E,
    input  logic       proc_valid_E,
    input  logic       proc_ready_in,
    output logic       noc_valid,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       flush_D,
    output logic       flush_E,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E,
    output logic       noc_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } noc_state_t;

    // Last WAIT count before the send is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    noc_state_t       state;
    noc_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_set;
    logic             lu;
    logic             cf;
    logic             stall_noc;

    // Forward select for one operand: M stage wins over W; r0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wen_m,
        input logic [4:0] dst_m,
        input logic       wen_w,
        input logic [4:0] dst_w
    );
        if (wen_m && (dst_m != 5'd0) && (dst_m == src))
            return 2'b10;
        else if (wen_w && (dst_w != 5'd0) && (dst_w == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwdA_E = fwd_sel(Rs_E, RegW_enable_M, Radd_M, RegW_enable_W, Radd_W);
    assign fwdB_E = fwd_sel(Rt_E, RegW_enable_M, Radd_M, RegW_enable_W, Radd_W);

    assign lu = Mem_Read_E && RegW_enable_E && (Radd_E != 5'd0) &&
                ((Radd_E == Rs_D) || (Radd_E == Rt_D));
    assign cf = branch_taken_E || Jump_E;

    // ERR drops the message, so the request is masked for that cycle.
    assign noc_valid = proc_valid_E && ((state == IDLE) || (state == WAIT));
    assign stall_noc = noc_valid && !proc_ready_in;

    // NoC FSM state, timeout counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            noc_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set)
                noc_timeout <= 1'b1;
        end
    end

    // NoC FSM next-state and counter update.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (proc_valid_E && !proc_ready_in) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT: begin
                if (!proc_valid_E || proc_ready_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ERR;
                    cnt_nxt     = '0;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ERR: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stall/flush priority: NoC hold defers everything, then flush, then bubble.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        if (stall_noc) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
        end else if (cf) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (lu) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counters of stalled-fetch and flushed-decode cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_F && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + CNT_ONE;
            if (flush_D && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + CNT_ONE;
        end
    end
`endif

endmodule
